// File: rtl/mvm_uart_pkg.sv
// Shared widths, frame constants and phase enum for the MVM UART host link.
package mvm_uart_pkg;

  localparam int unsigned BITS_PER_WORD = 8;
  localparam int unsigned R             = 8;
  localparam int unsigned C             = 8;
  localparam int unsigned W_X           = 8;
  localparam int unsigned W_K           = 8;
  localparam int unsigned W_Y_OUT       = 32;

  localparam int unsigned W_BUS_KX = R*C*W_K + C*W_X;
  localparam int unsigned W_BUS_Y  = R*W_Y_OUT;
  localparam int unsigned N_TX     = W_BUS_KX/BITS_PER_WORD;
  localparam int unsigned N_RX     = W_BUS_Y/BITS_PER_WORD;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, OUT} state_t;

endpackage

// File: rtl/mvm_uart_host_if.sv
// Operand (K/X) and result (Y) valid/ready buses of the MVM UART host.
interface mvm_uart_host_if;
  import mvm_uart_pkg::*;

  logic                s_kx_valid;
  logic                s_kx_ready;
  logic [W_BUS_KX-1:0] s_kx_data;
  logic                m_y_valid;
  logic                m_y_ready;
  logic [W_BUS_Y-1:0]  m_y_data;

  modport slave  (input  s_kx_valid, s_kx_data, m_y_ready,
                  output s_kx_ready, m_y_valid, m_y_data);
  modport master (output s_kx_valid, s_kx_data, m_y_ready,
                  input  s_kx_ready, m_y_valid, m_y_data);
endinterface

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 2-FF synchroniser, start-bit glitch filter, mid-bit sampling.
module uart_byte_rx
  import mvm_uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 200_000_000/9600
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic                     byte_valid,
  output logic [BITS_PER_WORD-1:0] byte_data,
  output logic                     stop_err
);

  localparam int unsigned CW   = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int unsigned HALF = CLOCKS_PER_PULSE/2;
  localparam int unsigned BW   = $clog2(BITS_PER_WORD);

  typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t               state, state_n;
  logic                    rx_s1, rx_s2, rx_d;
  logic [CW-1:0]           cnt, cnt_n;
  logic [BW-1:0]           bit_idx, bit_idx_n;
  logic [BITS_PER_WORD-1:0] shreg, shreg_n;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1   <= IDLE_LINE;
      rx_s2   <= IDLE_LINE;
      rx_d    <= IDLE_LINE;
      state   <= RX_HUNT;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_d    <= rx_s2;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // Counter runs from the synchronised falling edge; samples land mid-bit.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    unique case (state)
      RX_HUNT: begin
        cnt_n = '0;
        if (rx_d && !rx_s2) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s2 ? RX_HUNT : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == CW'(CLOCKS_PER_PULSE - 1)) begin
          cnt_n   = '0;
          shreg_n = {rx_s2, shreg[BITS_PER_WORD-1:1]};
          if (bit_idx == BW'(BITS_PER_WORD - 1)) state_n = RX_STOP;
          else bit_idx_n = bit_idx + BW'(1);
        end
      end
      RX_STOP: begin
        if (cnt == CW'(CLOCKS_PER_PULSE - 1)) begin
          cnt_n   = '0;
          state_n = RX_HUNT;
        end
      end
      default: state_n = RX_HUNT;
    endcase
  end

  // Byte is reported on the stop-bit sample cycle itself.
  assign byte_valid = (state == RX_STOP) && (cnt == CW'(CLOCKS_PER_PULSE - 1));
  assign byte_data  = shreg;
  assign stop_err   = byte_valid && !rx_s2;

endmodule

// File: rtl/mvm_uart_host.sv
// Host endpoint: serialises one K/X operand bus onto tx, collects N_RX result bytes from rx.
module mvm_uart_host
  import mvm_uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 200_000_000/9600,
  parameter int unsigned STOP_BITS_TX     = 1
) (
  input  logic            clk,
  input  logic            rstn,
  mvm_uart_host_if.slave  bus,
  output logic            tx,
  input  logic            rx,
  output logic            err_frame,
  output logic            err_overrun
);

  localparam int unsigned FRAME_BITS = 1 + BITS_PER_WORD + STOP_BITS_TX;
  localparam int unsigned CW  = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int unsigned FW  = $clog2(FRAME_BITS);
  localparam int unsigned BIW = $clog2(BITS_PER_WORD);
  localparam int unsigned TXW = $clog2(N_TX);
  localparam int unsigned RXW = $clog2(N_RX + 1);

  state_t                   state, state_n;
  logic [W_BUS_KX-1:0]      kx_sh, kx_sh_n;
  logic [CW-1:0]            bit_cnt, bit_cnt_n;
  logic [FW-1:0]            frame_idx, frame_idx_n, nidx;
  logic [TXW-1:0]           tx_byte, tx_byte_n;
  logic [RXW-1:0]           rx_cnt, rx_cnt_n;
  logic [W_BUS_Y-1:0]       y_q, y_n;
  logic                     ready_q, ready_n, valid_q, valid_n;
  logic                     tx_n, err_frame_n, err_overrun_n;
  logic [BITS_PER_WORD-1:0] cur_byte;

  logic                     rx_valid, rx_stop_err;
  logic [BITS_PER_WORD-1:0] rx_data;

  uart_byte_rx #(.CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)) u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .stop_err   (rx_stop_err)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      kx_sh       <= '0;
      bit_cnt     <= '0;
      frame_idx   <= '0;
      tx_byte     <= '0;
      rx_cnt      <= '0;
      y_q         <= '0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      tx          <= IDLE_LINE;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_n;
      kx_sh       <= kx_sh_n;
      bit_cnt     <= bit_cnt_n;
      frame_idx   <= frame_idx_n;
      tx_byte     <= tx_byte_n;
      rx_cnt      <= rx_cnt_n;
      y_q         <= y_n;
      ready_q     <= ready_n;
      valid_q     <= valid_n;
      tx          <= tx_n;
      err_frame   <= err_frame_n;
      err_overrun <= err_overrun_n;
    end
  end

  always_comb begin
    state_n       = state;
    kx_sh_n       = kx_sh;
    bit_cnt_n     = bit_cnt;
    frame_idx_n   = frame_idx;
    tx_byte_n     = tx_byte;
    rx_cnt_n      = rx_cnt;
    y_n           = y_q;
    tx_n          = tx;
    err_frame_n   = err_frame;
    err_overrun_n = err_overrun;
    nidx          = '0;
    cur_byte      = kx_sh[BITS_PER_WORD-1:0];

    // Result bytes are only wanted while a transaction is in flight.
    if (rx_valid) begin
      if ((state == SEND || state == WAIT) && rx_cnt != RXW'(N_RX)) begin
        y_n[32'(rx_cnt)*BITS_PER_WORD +: BITS_PER_WORD] = rx_data;
        rx_cnt_n = rx_cnt + RXW'(1);
      end else begin
        err_overrun_n = 1'b1;
      end
      if (rx_stop_err) err_frame_n = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (bus.s_kx_valid && ready_q) begin
          state_n       = SEND;
          kx_sh_n       = bus.s_kx_data;
          bit_cnt_n     = '0;
          frame_idx_n   = '0;
          tx_byte_n     = '0;
          rx_cnt_n      = '0;
          y_n           = '0;
          tx_n          = START_BIT;
          err_frame_n   = 1'b0;
          err_overrun_n = 1'b0;
        end
      end
      SEND: begin
        if (bit_cnt == CW'(CLOCKS_PER_PULSE - 1)) begin
          bit_cnt_n = '0;
          if (frame_idx == FW'(FRAME_BITS - 1)) begin
            frame_idx_n = '0;
            if (tx_byte == TXW'(N_TX - 1)) begin
              state_n = WAIT;
              tx_n    = IDLE_LINE;
            end else begin
              tx_byte_n = tx_byte + TXW'(1);
              kx_sh_n   = kx_sh >> BITS_PER_WORD;
              tx_n      = START_BIT;
            end
          end else begin
            nidx        = frame_idx + FW'(1);
            frame_idx_n = nidx;
            tx_n = (nidx <= FW'(BITS_PER_WORD)) ? cur_byte[BIW'(nidx - FW'(1))] : STOP_BIT;
          end
        end else begin
          bit_cnt_n = bit_cnt + CW'(1);
        end
      end
      WAIT: begin
        if (rx_cnt_n == RXW'(N_RX)) state_n = OUT;
      end
      OUT: begin
        if (bus.m_y_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    ready_n = (state_n == IDLE);
    valid_n = (state_n == OUT);
  end

  assign bus.s_kx_ready = ready_q;
  assign bus.m_y_valid  = valid_q;
  assign bus.m_y_data   = y_q;

endmodule

// File: tb/tb_mvm_uart_host.sv
// Directed/randomised bench for mvm_uart_host with a frame-level tx/rx reference model.
module tb_mvm_uart_host;
  import mvm_uart_pkg::*;

  localparam int unsigned CPP      = 4;
  localparam int unsigned FRAME    = 1 + BITS_PER_WORD + 1;
  localparam int unsigned SEND_CYC = N_TX*FRAME*CPP;

  logic clk = 1'b0;
  logic rstn, rx, tx, err_frame, err_overrun;

  mvm_uart_host_if bus();

  mvm_uart_host #(.CLOCKS_PER_PULSE(CPP), .STOP_BITS_TX(1)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .tx          (tx),
    .rx          (rx),
    .err_frame   (err_frame),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [W_BUS_Y-1:0]  y_exp;
  logic [W_BUS_KX-1:0] kx;
  logic [7:0]          rx_bytes [N_RX];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W_BUS_Y-1:0] obs, input logic [W_BUS_Y-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level cyc cycles after the accepting edge.
  function automatic logic exp_tx(input logic [W_BUS_KX-1:0] bus_kx, input int cyc);
    int frame = cyc / int'(FRAME*CPP);
    int pos   = (cyc % int'(FRAME*CPP)) / int'(CPP);
    logic [7:0] b;
    b = bus_kx[frame*8 +: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    return 1'b1;
  endfunction

  function automatic logic [W_BUS_KX-1:0] rand_kx();
    logic [W_BUS_KX-1:0] v;
    for (int w = 0; w < int'(W_BUS_KX/32); w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic send_kx(input logic [W_BUS_KX-1:0] bus_kx, input int ncyc);
    int waited = 0;
    bus.s_kx_data  = bus_kx;
    bus.s_kx_valid = 1'b1;
    while (bus.s_kx_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    chk1("kx_ready_idle", bus.s_kx_ready, 1'b1);
    tick();
    bus.s_kx_valid = 1'b0;
    chk1("err_frame_cleared", err_frame, 1'b0);
    chk1("err_overrun_cleared", err_overrun, 1'b0);
    for (int i = 0; i < ncyc; i++) begin
      chk1("tx_wave", tx, exp_tx(bus_kx, i));
      chk1("kx_ready_busy", bus.s_kx_ready, 1'b0);
      tick();
    end
    if (ncyc == int'(SEND_CYC)) begin
      chk1("tx_idle_after_send", tx, 1'b1);
      chk1("kx_ready_wait", bus.s_kx_ready, 1'b0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPP) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPP) tick();
    end
    rx = stop;
    repeat (CPP) tick();
    rx = 1'b1;
    repeat (2*CPP) tick();
  endtask

  // Plays rx_bytes back on rx; byte bad_idx gets a low stop bit.
  task automatic return_y(input int bad_idx);
    int waited = 0;
    for (int k = 0; k < int'(N_RX); k++) begin
      y_exp[k*8 +: 8] = rx_bytes[k];
      if (k == int'(N_RX) - 1) chk1("y_valid_early", bus.m_y_valid, 1'b0);
      send_byte(rx_bytes[k], k != bad_idx);
    end
    while (bus.m_y_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    chk1("y_valid_rise", bus.m_y_valid, 1'b1);
    chkw("y_data", bus.m_y_data, y_exp);
    chk1("kx_ready_out", bus.s_kx_ready, 1'b0);
  endtask

  task automatic handshake();
    bus.m_y_ready = 1'b1;
    tick();
    bus.m_y_ready = 1'b0;
    chk1("kx_ready_after_out", bus.s_kx_ready, 1'b1);
    chk1("y_valid_drop", bus.m_y_valid, 1'b0);
  endtask

  initial begin
    rstn           = 1'b0;
    rx             = 1'b1;
    bus.s_kx_valid = 1'b0;
    bus.s_kx_data  = '0;
    bus.m_y_ready  = 1'b0;
    y_exp          = '0;

    // Reset values
    repeat (3) tick();
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_kx_ready", bus.s_kx_ready, 1'b0);
    chk1("rst_y_valid", bus.m_y_valid, 1'b0);
    chkw("rst_y_data", bus.m_y_data, '0);
    chk1("rst_err_frame", err_frame, 1'b0);
    chk1("rst_err_overrun", err_overrun, 1'b0);
    rstn = 1'b1;
    tick();
    chk1("kx_ready_after_rst", bus.s_kx_ready, 1'b1);

    // Transaction 1: byte 0 = 0xA5, responder returns 0x01..0x20
    kx = rand_kx();
    kx[7:0] = 8'hA5;
    send_kx(kx, int'(SEND_CYC));
    for (int k = 0; k < int'(N_RX); k++) rx_bytes[k] = 8'(k + 1);
    return_y(-1);
    chkw("y_byte0", W_BUS_Y'(bus.m_y_data[7:0]), W_BUS_Y'(8'h01));
    chkw("y_byte31", W_BUS_Y'(bus.m_y_data[255:248]), W_BUS_Y'(8'h20));
    chk1("t1_err_frame", err_frame, 1'b0);
    chk1("t1_err_overrun", err_overrun, 1'b0);

    // Backpressure for 100 cycles
    for (int i = 0; i < 100; i++) begin
      chk1("bp_y_valid", bus.m_y_valid, 1'b1);
      chkw("bp_y_data", bus.m_y_data, y_exp);
      tick();
    end
    handshake();

    // Transaction 2: glitch, bad stop bit on byte 5, byte during OUT
    kx = rand_kx();
    send_kx(kx, int'(SEND_CYC));
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (12) tick();
    for (int k = 0; k < int'(N_RX); k++) rx_bytes[k] = 8'($urandom_range(0, 255));
    return_y(5);
    chk1("t2_err_frame", err_frame, 1'b1);
    chk1("t2_err_overrun_pre", err_overrun, 1'b0);
    send_byte(8'h55, 1'b1);
    chk1("t2_err_overrun", err_overrun, 1'b1);
    chk1("t2_y_valid_hold", bus.m_y_valid, 1'b1);
    chkw("t2_y_data_hold", bus.m_y_data, y_exp);
    handshake();

    // Transaction 3: reset during byte 10
    kx = rand_kx();
    send_kx(kx, 10*int'(FRAME*CPP) + 13);
    rstn = 1'b0;
    tick();
    chk1("mid_rst_tx", tx, 1'b1);
    chk1("mid_rst_kx_ready", bus.s_kx_ready, 1'b0);
    tick();
    rstn = 1'b1;
    tick();
    chk1("post_rst_kx_ready", bus.s_kx_ready, 1'b1);
    chk1("post_rst_y_valid", bus.m_y_valid, 1'b0);
    chkw("post_rst_y_data", bus.m_y_data, '0);
    chk1("post_rst_err_frame", err_frame, 1'b0);

    // Transaction 4: fresh restart from byte 0
    kx = rand_kx();
    send_kx(kx, int'(SEND_CYC));
    for (int k = 0; k < int'(N_RX); k++) rx_bytes[k] = 8'($urandom_range(0, 255));
    return_y(-1);
    chk1("t4_err_frame", err_frame, 1'b0);
    chk1("t4_err_overrun", err_overrun, 1'b0);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mvm_uart_host.md
# mvm_uart_host

Host-side endpoint of the matrix-vector-multiply UART link, used as the FPGA-side driver when the MVM system sits on a second device and as the bench host model. It accepts one flattened K/X operand bus over a valid/ready handshake and serialises it onto `tx`. It then collects the R sign-extended 32-bit results returned on `rx` and presents them as one parallel Y word over a valid/ready handshake.

## Interface
- `CLOCKS_PER_PULSE`, 200_000_000/9600: clock cycles per UART bit.
- `BITS_PER_WORD`, 8: data bits per UART frame.
- `STOP_BITS_TX`, 1: stop bits sent per frame; the receiver needs ≥1.
- `R`, 8: matrix rows.
- `C`, 8: matrix columns.
- `W_X`, 8: X element width.
- `W_K`, 8: K element width.
- `W_Y_OUT`, 32: returned result width per row.
- Derived: `W_BUS_KX = R*C*W_K + C*W_X` (576), `W_BUS_Y = R*W_Y_OUT` (256), `N_TX = W_BUS_KX/BITS_PER_WORD` (72), `N_RX = W_BUS_Y/BITS_PER_WORD` (32).

Ports (one clock `clk`; reset `rstn` is synchronous and active-low):
- `clk`  in  1  clock.
- `rstn`  in  1  synchronous active-low reset.
- `s_kx_valid`  in  1  operand bus valid.
- `s_kx_ready`  out  1  operand bus ready.
- `s_kx_data`  in  W_BUS_KX  flattened K then X, same packing as the MVM core input.
- `tx`  out  1  UART line to the MVM system.
- `rx`  in  1  UART line from the MVM system; asynchronous.
- `m_y_valid`  out  1  result valid.
- `m_y_ready`  in  1  result ready.
- `m_y_data`  out  W_BUS_Y  R results, row r at `[W_Y_OUT*(r+1)-1 : W_Y_OUT*r]`.
- `err_frame`  out  1  sticky: a received stop bit sampled low.
- `err_overrun`  out  1  sticky: a byte arrived while in IDLE or OUT.

## Operation
- **Frame format:** start bit 0, data bits LSB first, `STOP_BITS_TX` stop bits of 1. Byte 0 is `s_kx_data[7:0]`; bytes go out in ascending order. Received byte k lands in `m_y_data[8k+7:8k]`.
- **IDLE:** `s_kx_ready`=1. On `s_kx_valid && s_kx_ready`, capture the bus into a shift register, clear both error flags, clear the byte counters, go to SEND.
- **SEND:** serialise `N_TX` frames back to back with no idle gap. After the last stop bit completes, go to WAIT.
- **WAIT:** stay until `N_RX` bytes have been received, then go to OUT.
- **Receiver:** always enabled. `rx` passes through a 2-FF synchroniser that resets to 1. A falling edge starts a frame. The start bit is re-checked at `CLOCKS_PER_PULSE/2`; if it reads high, treat it as a glitch, drop it and return to hunting. Data bits and the stop bit are sampled at mid-bit.
- **Byte storage:** bytes received in SEND or WAIT are stored and counted; bytes received in IDLE or OUT are dropped and set `err_overrun`. A low stop bit sets `err_frame`; the byte is still stored and counted.
- **OUT:** `m_y_valid`=1 and `m_y_data` is held stable. On `m_y_ready` go to IDLE.
- **Reset:** all state clears regardless of phase. Reset values: `tx`=1, `s_kx_ready`=0 while `rstn`=0 and 1 from the first cycle after release, `m_y_valid`=0, `m_y_data`=0, both error flags 0.

## Timing
- **Start of transmit:** `tx` drops to the start bit on the cycle after the accepting edge. Each bit holds exactly `CLOCKS_PER_PULSE` cycles.
- **SEND duration:** `N_TX*(1+BITS_PER_WORD+STOP_BITS_TX)*CLOCKS_PER_PULSE` cycles.
- **Receive latency:** the synchroniser adds 2 cycles. `m_y_valid` rises on the cycle after the last byte's stop-bit sample.
- **`s_kx_ready`:** low from acceptance until the OUT handshake completes; one transaction is in flight at a time.
- **Output handshake:** `m_y_valid` stays high under backpressure indefinitely. On an OUT handshake the block returns to IDLE, so `s_kx_ready` reads 1 on the next cycle.
- **Simultaneous events:** a start-bit edge on `rx` in the same cycle as the IDLE→SEND transition counts as a SEND-phase byte.

## Structure
- **Shared package:** `mvm_uart_pkg` holds the derived widths `W_BUS_KX`, `W_BUS_Y`, `N_TX`, `N_RX`, the state enum (IDLE, SEND, WAIT, OUT) and the frame bit constants.
- **Sub-module:** `uart_byte_rx`, containing the synchroniser, mid-bit sampler and stop check. It outputs `byte_valid` (1-cycle pulse), `byte_data` and `stop_err`.
- **Inline in the top:** the TX serialiser, the FSM and the Y assembly register.

## Test plan
Run all scenarios with `CLOCKS_PER_PULSE`=4.
1. **Reset:** hold `rstn`=0 for 3 cycles → `tx`=1, `m_y_valid`=0, errors 0; `s_kx_ready`=1 on the cycle after release.
2. **First-byte waveform:** `s_kx_data[7:0]`=0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, starting the cycle after accept. `s_kx_ready` stays 0, and SEND lasts 2880 cycles.
3. **Full loopback:** a bench responder returns bytes 0x01..0x20 after the TX → `m_y_valid` with `m_y_data[7:0]`=0x01, `[255:248]`=0x20, `err_frame`=0.
4. **Backpressure:** hold `m_y_ready`=0 for 100 cycles → `m_y_valid`=1 and `m_y_data` unchanged throughout. Then raise it for 1 cycle → `s_kx_ready`=1 on the next cycle.
5. **Line errors:** byte 5 returned with stop bit 0 → `err_frame`=1 and Y still delivered after 32 bytes. A 1-cycle low glitch on `rx` → no byte counted. A byte sent during OUT → `err_overrun`=1.
6. **Reset mid-transmit:** assert `rstn`=0 during TX byte 10 → `tx`=1 on the next edge. After release, `s_kx_ready`=1 and a new transaction restarts from byte 0.
